pipelined_csel_adder: RTL and testbench

//  Parametrised, pipelined carry-select adder/subtractor with valid/ready handshake.

---
 rtl/pipelined_csel_adder.sv | 145 ++++++++++++++
 tb/tb_pipelined_csel_adder.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pipelined_csel_adder.sv
`default_nettype none
// ============================================================================
//  Module   : pipelined_csel_adder
//  Purpose  : Pipelined carry-select adder/subtractor with a valid/ready
//             handshake. Operands are split into BLK-bit chunks. Each stage
//             resolves one chunk: it computes the chunk sum for carry-in 0
//             and for carry-in 1, then picks one using the carry registered
//             by the previous stage. One operation is accepted per cycle.
//             The result appears after a fixed latency of WIDTH/BLK stages.
//  Ports    : clk        rising-edge clock
//             rst_n      asynchronous active-low reset
//             in_valid   operand set present
//             in_ready   block can accept this cycle
//             A, B       operands (WIDTH bits)
//             Cin        carry-in (add mode only)
//             sub        0: A+B+Cin, 1: A-B (A + ~B + 1, Cin ignored)
//             out_valid  result present
//             out_ready  downstream accepts result
//             sum        result (WIDTH bits)
//             Cout       carry-out of MSB (in subtract mode, 1 = no borrow)
//             ovf        signed overflow (carry into MSB ^ carry out of MSB)
//  Revision : 1.0  initial release
// ============================================================================
module pipelined_csel_adder #(
  parameter int WIDTH = 16,
  parameter int BLK   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             Cout,
  output logic             ovf
);

  localparam int c_nstg = WIDTH / BLK;

  // Per-stage pipeline registers. Index k holds the state after chunk k
  // has been resolved.
  logic [c_nstg-1:0]            r_v;
  logic [c_nstg-1:0]            r_c;
  logic [c_nstg-1:0][WIDTH-1:0] r_a;
  logic [c_nstg-1:0][WIDTH-1:0] r_b;
  logic [c_nstg-1:0][WIDTH-1:0] r_sum;
  logic                         r_ovf;

  logic             w_adv;
  logic [WIDTH-1:0] w_bx;
  logic             w_c0;

  // Input chains. Element 0 is the port side. Element k+1 is the output of
  // register stage k. Stage k reads element k, so no stage needs an
  // out-of-range "previous" index, even when there is only one stage.
  logic [c_nstg:0]            w_vchain;
  logic [c_nstg:0]            w_cchain;
  logic [c_nstg:0][WIDTH-1:0] w_achain;
  logic [c_nstg:0][WIDTH-1:0] w_bchain;
  logic [c_nstg:0][WIDTH-1:0] w_schain;

  logic [c_nstg-1:0][BLK:0]     w_s0;
  logic [c_nstg-1:0][BLK:0]     w_s1;
  logic [c_nstg-1:0][BLK:0]     w_sel;
  logic [c_nstg-1:0][WIDTH-1:0] w_snext;
  logic                         w_cmsb;
  logic                         w_ovf;
  logic                         w_unused;

  // The whole pipe moves together. The input is accepted whenever the
  // output slot is empty or is being drained in this cycle.
  assign w_adv    = ~r_v[c_nstg-1] | out_ready;
  assign in_ready = w_adv;

  // Subtraction becomes addition of the inverted B with a forced carry-in.
  assign w_bx = sub ? ~B : B;
  assign w_c0 = sub ? 1'b1 : Cin;

  assign w_vchain = {r_v, in_valid};
  assign w_cchain = {r_c, w_c0};
  assign w_achain = {r_a, A};
  assign w_bchain = {r_b, w_bx};
  assign w_schain = {r_sum, {WIDTH{1'b0}}};

  always_comb begin
    w_s0    = '0;
    w_s1    = '0;
    w_sel   = '0;
    w_snext = '0;
    for (int k = 0; k < c_nstg; k++) begin
      // Both candidate chunk sums are BLK+1 bits wide. The top bit is the
      // chunk carry-out.
      w_s0[k]  = {1'b0, w_achain[k][k*BLK +: BLK]} + {1'b0, w_bchain[k][k*BLK +: BLK]};
      w_s1[k]  = {1'b0, w_achain[k][k*BLK +: BLK]} + {1'b0, w_bchain[k][k*BLK +: BLK]}
               + {{BLK{1'b0}}, 1'b1};
      w_sel[k] = w_cchain[k] ? w_s1[k] : w_s0[k];
      w_snext[k] = w_schain[k];
      w_snext[k][k*BLK +: BLK] = w_sel[k][BLK-1:0];
    end
  end

  // Recover the carry into bit WIDTH-1 from the sum bit and the operand
  // bits of the MSB. Then compare it with the carry out of the MSB.
  assign w_cmsb = w_sel[c_nstg-1][BLK-1] ^ w_achain[c_nstg-1][WIDTH-1]
                ^ w_bchain[c_nstg-1][WIDTH-1];
  assign w_ovf  = w_cmsb ^ w_sel[c_nstg-1][BLK];

  // The last stage has no operands left to forward.
  assign w_unused = ^{w_achain[c_nstg], w_bchain[c_nstg]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v   <= '0;
      r_c   <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_sum <= '0;
      r_ovf <= 1'b0;
    end else if (w_adv) begin
      // Data registers load even on bubbles. A bubbled stage's data is
      // never presented as valid. A stall (w_adv=0) freezes every stage,
      // including the output.
      for (int k = 0; k < c_nstg; k++) begin
        r_v[k]   <= w_vchain[k];
        r_c[k]   <= w_sel[k][BLK];
        r_a[k]   <= w_achain[k];
        r_b[k]   <= w_bchain[k];
        r_sum[k] <= w_snext[k];
      end
      r_ovf <= w_ovf;
    end
  end

  assign out_valid = r_v[c_nstg-1];
  assign sum       = r_sum[c_nstg-1];
  assign Cout      = r_c[c_nstg-1];
  assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_csel_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipelined_csel_adder
//  Purpose  : Self-checking bench for pipelined_csel_adder. It drives a
//             16/4 instance with directed and random traffic and checks the
//             results against an arithmetic reference queue. It also drives
//             an 8/8 single-stage instance with random operations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipelined_csel_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, Cin, sub, out_valid, out_ready, Cout, ovf;
  logic [15:0] A, B, sum;

  logic        in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8, cout8, ovf8;
  logic [7:0]  a8, b8, sum8;

  int          checks = 0;
  int          errors = 0;
  logic [17:0] q[$];          // expected {ovf, Cout, sum}, oldest first
  logic        last_ov;
  logic        frz_armed;
  logic [18:0] frz_val;
  int          run, max_run;

  always #5 clk = ~clk;

  pipelined_csel_adder #(.WIDTH(16), .BLK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Cin(Cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .Cout(Cout), .ovf(ovf));

  pipelined_csel_adder #(.WIDTH(8), .BLK(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .A(a8), .B(b8), .Cin(cin8), .sub(sub8), .out_valid(out_valid8),
    .out_ready(out_ready8), .sum(sum8), .Cout(cout8), .ovf(ovf8));

  // Reference: a w-bit add of A and (sub ? ~B : B) with carry-in
  // (sub ? 1 : Cin), using plain integer arithmetic.
  function automatic logic [17:0] ref_calc(input int w, input logic [15:0] a,
                                           input logic [15:0] b, input logic ci,
                                           input logic sb);
    int unsigned mask, bx, full, s;
    logic co, ov;
    mask = (32'd1 << w) - 32'd1;
    bx   = sb ? (~32'(b) & mask) : (32'(b) & mask);
    full = (32'(a) & mask) + bx + (sb ? 32'd1 : 32'(ci));
    s    = full & mask;
    co   = full[w];
    ov   = (a[w-1] == bx[w-1]) && (s[w-1] != a[w-1]);
    return {ov, co, s[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle on the 16-bit instance. Outputs are sampled on the
  // falling edge. The reference queue is updated for the next rising edge.
  task automatic cyc(input logic iv, input logic [15:0] a, input logic [15:0] b,
                     input logic ci, input logic sb, input logic ordy);
    in_valid = iv; A = a; B = b; Cin = ci; sub = sb; out_ready = ordy;
    @(negedge clk);
    check("in_ready", 32'(in_ready), 32'(!out_valid || out_ready));
    if (frz_armed)
      check("stall_hold", 32'({out_valid, ovf, Cout, sum}), 32'(frz_val));
    if (out_valid) begin
      if (q.size() == 0) check("spurious_valid", 32'(out_valid), 32'd0);
      else               check("result", 32'({ovf, Cout, sum}), 32'(q[0]));
    end
    last_ov   = out_valid;
    run       = out_valid ? run + 1 : 0;
    if (run > max_run) max_run = run;
    frz_armed = out_valid && !out_ready;
    frz_val   = {out_valid, ovf, Cout, sum};
    if (out_valid && out_ready && q.size() > 0) void'(q.pop_front());
    if (iv && in_ready) q.push_back(ref_calc(16, a, b, ci, sb));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    logic [17:0] e8;
    rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; Cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0; out_ready8 = 1'b1;
    frz_armed = 1'b0; run = 0; max_run = 0; last_ov = 1'b0;
    #3;
    check("reset_outputs", 32'({out_valid, sum, Cout, ovf}), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Latency and carry ripple through every chunk.
    cyc(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    n = 0;
    do begin
      idle(1);
      n++;
    end while (!last_ov && n < 20);
    check("latency", 32'(n), 32'd4);
    idle(4);

    // Directed add/sub corner values.
    cyc(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 16'h1234, 16'h4321, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 16'h8000, 16'h0001, 1'b1, 1'b1, 1'b1);   // Cin ignored in sub
    cyc(1'b1, 16'h0000, 16'h0001, 1'b0, 1'b1, 1'b1);
    idle(8);
    check("directed_drained", 32'(q.size()), 32'd0);

    // 8 back-to-back operations must give 8 consecutive results.
    max_run = 0;
    for (int i = 0; i < 8; i++)
      cyc(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    idle(8);
    check("b2b_run", 32'(max_run), 32'd8);
    check("b2b_drained", 32'(q.size()), 32'd0);

    // Fill the pipe with the output blocked, stall, then release.
    for (int i = 0; i < 9; i++)
      cyc(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    check("stall_fill", 32'(q.size()), 32'd4);
    idle(8);
    check("stall_drained", 32'(q.size()), 32'd0);

    // Random traffic with random bubbles and backpressure.
    for (int i = 0; i < 300; i++)
      cyc(1'(($urandom % 4) != 0), 16'($urandom), 16'($urandom), 1'($urandom),
          1'($urandom), 1'(($urandom % 3) != 0));
    idle(10);
    check("random_drained", 32'(q.size()), 32'd0);

    // Reset with 3 operations in flight, the oldest waiting at the output.
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    check("pre_reset_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("reset_async_valid", 32'(out_valid), 32'd0);
    check("reset_async_data", 32'({sum, Cout, ovf}), 32'd0);
    q.delete();
    frz_armed = 1'b0; run = 0; max_run = 0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    idle(8);
    check("no_stale_after_reset", 32'(max_run), 32'd0);

    // Single-stage 8-bit instance: the result is registered on the accept edge.
    for (int i = 0; i < 40; i++) begin
      in_valid8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom);
      cin8 = 1'($urandom); sub8 = 1'($urandom); out_ready8 = 1'b1;
      e8 = ref_calc(8, {8'h00, a8}, {8'h00, b8}, cin8, sub8);
      @(posedge clk);
      @(negedge clk);
      check("w8_valid", 32'(out_valid8), 32'd1);
      check("w8_result", 32'({ovf8, cout8, sum8}), 32'({e8[17:16], e8[7:0]}));
    end
    in_valid8 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
